// File: rtl/tape_arbiter.sv
// tape_arbiter: shares the single-port tape RAM between the brainhack core and a
// host/debug port. The host gets the RAM for exactly one cycle per request. The
// core is stalled during that cycle and replays its access afterwards. A halt
// mode freezes the core so the host can do back-to-back accesses.
//
// Ports:
//   i_clock, i_reset_n      rising-edge clock, synchronous active-low reset
//   i_core_*                core tape access (req/we/addr/wdata)
//   o_core_rdata            tape read data to core (don't-care while stalled)
//   o_core_stall            core must hold and repeat its access
//   i_host_*                host request (level, held until ack), we/addr/wdata
//   i_host_halt             freeze core, host gets exclusive RAM
//   o_host_ack              one-cycle completion pulse
//   o_host_rdata            registered read data, valid with ack
//   o_host_halted           core frozen
//   o_ram_*, i_ram_rdata    tape RAM port (combinational read, write on edge)
module tape_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_core_req,
  input  logic                  i_core_we,
  input  logic [ADDR_WIDTH-1:0] i_core_addr,
  input  logic [DATA_WIDTH-1:0] i_core_wdata,
  output logic [DATA_WIDTH-1:0] o_core_rdata,
  output logic                  o_core_stall,
  input  logic                  i_host_req,
  input  logic                  i_host_we,
  input  logic [ADDR_WIDTH-1:0] i_host_addr,
  input  logic [DATA_WIDTH-1:0] i_host_wdata,
  input  logic                  i_host_halt,
  output logic                  o_host_ack,
  output logic [DATA_WIDTH-1:0] o_host_rdata,
  output logic                  o_host_halted,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

  // Counter only has to reach STARVE_LIMIT-1 before the host is forced in.
  localparam int unsigned CNT_WIDTH = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STARVE_LIMIT - 1);

  localparam logic [1:0] CORE_OWN = 2'd0;
  localparam logic [1:0] HOST_OWN = 2'd1;
  localparam logic [1:0] HALTED   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  pending;

  // A request still high during its own ack cycle is the old one, not a new one.
  assign pending = i_host_req & ~ack_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      CORE_OWN: begin
        if (i_host_halt) begin
          state_d = HALTED;
        end else if (pending && (!i_core_req || cnt_q == CNT_MAX)) begin
          state_d = HOST_OWN;
        end
      end
      HOST_OWN: state_d = i_host_halt ? HALTED : CORE_OWN;
      HALTED: begin
        if (pending) begin
          state_d = HOST_OWN;
        end else if (!i_host_halt) begin
          state_d = CORE_OWN;
        end
      end
      default: state_d = CORE_OWN;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    // Count only cycles the core actually takes while the host waits.
    if (state_q == CORE_OWN && state_d == CORE_OWN && pending && i_core_req) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign ack_d   = (state_q == HOST_OWN);
  assign rdata_d = (state_q == HOST_OWN) ? i_ram_rdata : rdata_q;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q <= CORE_OWN;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM mux is driven by the state register only, never by the request inputs.
  always_comb begin
    o_ram_we    = 1'b0;
    o_ram_addr  = i_core_addr;
    o_ram_wdata = i_core_wdata;
    case (state_q)
      CORE_OWN: o_ram_we = i_core_req & i_core_we;
      HOST_OWN: begin
        o_ram_we    = i_host_we;
        o_ram_addr  = i_host_addr;
        o_ram_wdata = i_host_wdata;
      end
      default: o_ram_we = 1'b0;
    endcase
    // No write may reach the RAM while reset is held.
    o_ram_we = o_ram_we & i_reset_n;
  end

  assign o_core_rdata  = i_ram_rdata;
  assign o_core_stall  = (state_q != CORE_OWN);
  assign o_host_halted = (state_q == HALTED);
  assign o_host_ack    = ack_q;
  assign o_host_rdata  = rdata_q;

endmodule

// File: tb/tb_tape_arbiter.sv
module tb_tape_arbiter;

  logic       clock;
  logic       reset_n;
  logic       core_req, core_we;
  logic [7:0] core_addr, core_wdata, core_rdata;
  logic       core_stall;
  logic       host_req, host_we, host_halt;
  logic [7:0] host_addr, host_wdata, host_rdata;
  logic       host_ack, host_halted;
  logic       ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;

  logic [7:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  tape_arbiter #(
    .ADDR_WIDTH  (8),
    .DATA_WIDTH  (8),
    .STARVE_LIMIT(4)
  ) dut (
    .i_clock      (clock),
    .i_reset_n    (reset_n),
    .i_core_req   (core_req),
    .i_core_we    (core_we),
    .i_core_addr  (core_addr),
    .i_core_wdata (core_wdata),
    .o_core_rdata (core_rdata),
    .o_core_stall (core_stall),
    .i_host_req   (host_req),
    .i_host_we    (host_we),
    .i_host_addr  (host_addr),
    .i_host_wdata (host_wdata),
    .i_host_halt  (host_halt),
    .o_host_ack   (host_ack),
    .o_host_rdata (host_rdata),
    .o_host_halted(host_halted),
    .o_ram_we     (ram_we),
    .o_ram_addr   (ram_addr),
    .o_ram_wdata  (ram_wdata),
    .i_ram_rdata  (ram_rdata)
  );

  // Tape RAM model: combinational read, write on the rising edge.
  always @(posedge clock) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_halt = 1'b0;

    // Reset: a core write presented during reset must not reach the RAM.
    tick();
    core_req = 1'b1; core_we = 1'b1; core_addr = 8'd50; core_wdata = 8'hEE;
    mid();
    chk("rst_ram_we", 32'(ram_we), 0);
    tick();
    reset_n = 1'b1; core_req = 1'b0; core_we = 1'b0;
    mid();
    chk("rst_ack", 32'(host_ack), 0);
    chk("rst_rdata", 32'(host_rdata), 0);
    chk("rst_halted", 32'(host_halted), 0);
    chk("rst_stall", 32'(core_stall), 0);

    // Core-only traffic: write 10 to addr 0, read it back, no stall.
    tick();
    core_req = 1'b1; core_we = 1'b1; core_addr = 8'd0; core_wdata = 8'd10;
    mid();
    chk("core_wr_we", 32'(ram_we), 1);
    chk("core_wr_stall", 32'(core_stall), 0);
    tick();
    core_we = 1'b0;
    mid();
    chk("core_rd_data", 32'(core_rdata), 10);
    chk("core_rd_stall", 32'(core_stall), 0);
    tick();
    core_we = 1'b1; core_addr = 8'd50; core_wdata = 8'h21;
    mid();
    chk("core_wr50_stall", 32'(core_stall), 0);
    tick();
    core_req = 1'b0; core_we = 1'b0;

    // Host write with core idle: req at N, HOST_OWN at N+1, ack at N+2.
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'd3; host_wdata = 8'h5A;
    mid();
    chk("hw_n_ack", 32'(host_ack), 0);
    chk("hw_n_stall", 32'(core_stall), 0);
    tick();
    mid();
    chk("hw_own_stall", 32'(core_stall), 1);
    chk("hw_own_we", 32'(ram_we), 1);
    chk("hw_own_addr", 32'(ram_addr), 3);
    chk("hw_own_ack", 32'(host_ack), 0);
    tick();
    host_req = 1'b0;
    mid();
    chk("hw_ack", 32'(host_ack), 1);
    tick();
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'd3;
    mid();
    chk("hr_n_ack", 32'(host_ack), 0);
    tick();
    mid();
    chk("hr_own_we", 32'(ram_we), 0);
    chk("hr_own_stall", 32'(core_stall), 1);
    tick();
    host_req = 1'b0;
    mid();
    chk("hr_ack", 32'(host_ack), 1);
    chk("hr_rdata", 32'(host_rdata), 'h5A);

    // Starvation bound: core busy every cycle writing 0x40+i to addr 9.
    // Four core-owned cycles, then HOST_OWN, then ack with the last core value.
    tick();
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'd9;
    core_req = 1'b1; core_we = 1'b1; core_addr = 8'd9;
    for (int i = 0; i < 4; i++) begin
      core_wdata = 8'(8'h40 + i);
      mid();
      chk("starve_core_stall", 32'(core_stall), 0);
      chk("starve_core_we", 32'(ram_we), 1);
      tick();
    end
    core_wdata = 8'h44;
    mid();
    chk("starve_own_stall", 32'(core_stall), 1);
    chk("starve_own_we", 32'(ram_we), 0);
    chk("starve_own_addr", 32'(ram_addr), 9);
    tick();
    host_req = 1'b0; core_we = 1'b0;
    mid();
    chk("starve_ack", 32'(host_ack), 1);
    chk("starve_rdata", 32'(host_rdata), 'h43);
    chk("starve_core_rd", 32'(core_rdata), 'h43);
    chk("starve_after_stall", 32'(core_stall), 0);

    // Halt: core keeps trying to write 0xFF to addr 30 the whole time.
    tick();
    core_we = 1'b1; core_addr = 8'd30; core_wdata = 8'hFF; host_halt = 1'b1;
    mid();
    chk("halt_req_halted", 32'(host_halted), 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      host_req = 1'b1; host_we = 1'b1;
      host_addr = 8'(30 + k); host_wdata = 8'(8'hA0 + k);
      mid();
      chk("halt_halted", 32'(host_halted), 1);
      chk("halt_stall", 32'(core_stall), 1);
      chk("halt_idle_we", 32'(ram_we), 0);
      tick();
      mid();
      chk("halt_own_stall", 32'(core_stall), 1);
      chk("halt_own_we", 32'(ram_we), 1);
      tick();
      if (k == 2) begin
        host_req = 1'b0; host_halt = 1'b0; core_we = 1'b0;
      end
      mid();
      chk("halt_ack", 32'(host_ack), 1);
      chk("halt_ack_stall", 32'(core_stall), 1);
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      core_addr = 8'(30 + j);
      mid();
      chk("resume_stall", 32'(core_stall), 0);
      chk("resume_halted", 32'(host_halted), 0);
      chk("resume_rdata", 32'(core_rdata), 32'('hA0 + j));
      tick();
    end
    core_req = 1'b0;

    // Reset during HOST_OWN: first a completed read so rdata is non-zero.
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'd3;
    tick();
    tick();
    host_req = 1'b0;
    mid();
    chk("prerst_rdata", 32'(host_rdata), 'h5A);
    tick();
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'd50; host_wdata = 8'h99;
    tick();
    reset_n = 1'b0;
    mid();
    chk("rst_own_we", 32'(ram_we), 0);
    tick();
    reset_n = 1'b1; host_req = 1'b0; host_we = 1'b0;
    mid();
    chk("rst_own_ack", 32'(host_ack), 0);
    chk("rst_own_rdata", 32'(host_rdata), 0);
    chk("rst_own_stall", 32'(core_stall), 0);
    chk("rst_own_halted", 32'(host_halted), 0);
    tick();
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'd50;
    mid();
    chk("rst_cell_kept", 32'(core_rdata), 'h21);
    tick();
    core_req = 1'b0;

    // Halt together with a pending request: HALTED, then HOST_OWN, ack at N+3.
    host_halt = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 8'd3;
    mid();
    chk("hp_n_stall", 32'(core_stall), 0);
    tick();
    mid();
    chk("hp_halted", 32'(host_halted), 1);
    chk("hp_halted_we", 32'(ram_we), 0);
    chk("hp_halted_ack", 32'(host_ack), 0);
    tick();
    mid();
    chk("hp_own_stall", 32'(core_stall), 1);
    chk("hp_own_halted", 32'(host_halted), 0);
    chk("hp_own_addr", 32'(ram_addr), 3);
    tick();
    host_req = 1'b0; host_halt = 1'b0;
    mid();
    chk("hp_ack", 32'(host_ack), 1);
    chk("hp_rdata", 32'(host_rdata), 'h5A);
    chk("hp_ack_halted", 32'(host_halted), 1);
    tick();
    mid();
    chk("hp_end_stall", 32'(core_stall), 0);
    chk("hp_end_halted", 32'(host_halted), 0);
    chk("hp_end_ack", 32'(host_ack), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
